// File: rtl/hex_step_display_pkg.sv
// Shared constants and types for the stepping/display front end.
// No logic; glyphs are active-low with bit order gfedcba.
// Imported by the encoder and the top level.
package hex_step_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Entry n is the glyph for hex digit n (entry 0 sits in the low bits).
  localparam logic [15:0][6:0] SEG_GLYPH = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PRESS,
    PRESSED,
    WAIT_RELEASE
  } dbnc_state_t;

endpackage

// File: rtl/hex_step_display_if.sv
// Control and display bundle between the board-side driver and the stepping block.
// Pure wiring, no latency.
// No backpressure: step_en is a one-cycle strobe the consumer must take.
interface hex_step_display_if #(
  parameter int N_DIGITS = 8
);

  logic                    run_mode;
  logic                    step_btn;
  logic [4*N_DIGITS-1:0]   value;
  logic                    step_en;
  logic [15:0]             step_count;
  logic [7*N_DIGITS-1:0]   hex;

  modport master (
    output run_mode, step_btn, value,
    input  step_en, step_count, hex
  );

  modport slave (
    input  run_mode, step_btn, value,
    output step_en, step_count, hex
  );

endinterface

// File: rtl/hex_seg7.sv
// 4-bit hex digit to active-low 7-segment encoder with a blanking override.
// Combinational, zero latency.
// No backpressure.
module hex_seg7
  import hex_step_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  assign seg = blank ? SEG_BLANK : SEG_GLYPH[nibble];

endmodule

// File: rtl/hex_step_display.sv
// Generates the datapath step strobe (divider or debounced button) and displays a captured word.
// step_en registered; capture 1 cycle after step_en, hex 2 cycles after step_en.
// No backpressure: every step_en pulse is captured and counted unconditionally.
module hex_step_display
  import hex_step_pkg::*;
#(
  parameter int DIV_MAX  = 50_000_000,
  parameter int DEBOUNCE = 500_000,
  parameter int N_DIGITS = 8,
  parameter int BLANK_LZ = 1
) (
  input  logic               clock,
  input  logic               reset,
  hex_step_display_if.slave  bus
);

  localparam int DIV_W = $clog2(DIV_MAX + 1);
  localparam int DEB_W = $clog2(DEBOUNCE + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_MAX - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE - 1);
  // All digits blank except digit 0, which shows '0'.
  localparam logic [7*N_DIGITS-1:0] HEX_RST =
    ({(7*N_DIGITS){1'b1}} << 7) | (7*N_DIGITS)'(SEG_GLYPH[0]);

  logic [DIV_W-1:0]        div_cnt;
  logic                    div_hit;
  logic                    btn_meta;
  logic                    btn_sync;
  dbnc_state_t             state;
  dbnc_state_t             state_nxt;
  logic [DEB_W-1:0]        deb_cnt;
  logic [DEB_W-1:0]        deb_cnt_nxt;
  logic                    btn_pulse;
  logic                    step_en_r;
  logic [15:0]             step_count_r;
  logic [4*N_DIGITS-1:0]   captured;
  logic [N_DIGITS-1:0]     blank;
  logic [7*N_DIGITS-1:0]   hex_nxt;
  logic [7*N_DIGITS-1:0]   hex_r;

  assign bus.step_en    = step_en_r;
  assign bus.step_count = step_count_r;
  assign bus.hex        = hex_r;

  // Two-flop synchroniser for the asynchronous push-button.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      btn_meta <= bus.step_btn;
      btn_sync <= btn_meta;
    end
  end

  // Free-running divider; held at 0 outside run mode so re-entry starts a full period.
  assign div_hit = bus.run_mode && (div_cnt == DIV_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (!bus.run_mode || div_hit) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Debounce FSM state and stability counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      deb_cnt <= '0;
    end else begin
      state   <= state_nxt;
      deb_cnt <= deb_cnt_nxt;
    end
  end

  // Debounce next-state: one pulse per accepted press, run mode parks the FSM in IDLE.
  always_comb begin
    state_nxt   = state;
    deb_cnt_nxt = deb_cnt;
    btn_pulse   = 1'b0;
    if (bus.run_mode) begin
      state_nxt   = IDLE;
      deb_cnt_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          if (btn_sync) begin
            state_nxt   = WAIT_PRESS;
            deb_cnt_nxt = '0;
          end
        end
        WAIT_PRESS: begin
          if (!btn_sync) begin
            state_nxt = IDLE;
          end else if (deb_cnt == DEB_LAST) begin
            state_nxt = PRESSED;
            btn_pulse = 1'b1;
          end else begin
            deb_cnt_nxt = deb_cnt + DEB_W'(1);
          end
        end
        PRESSED: begin
          if (!btn_sync) begin
            state_nxt   = WAIT_RELEASE;
            deb_cnt_nxt = '0;
          end
        end
        WAIT_RELEASE: begin
          if (btn_sync) begin
            state_nxt = PRESSED;
          end else if (deb_cnt == DEB_LAST) begin
            state_nxt = IDLE;
          end else begin
            deb_cnt_nxt = deb_cnt + DEB_W'(1);
          end
        end
        default: begin
          state_nxt   = IDLE;
          deb_cnt_nxt = '0;
        end
      endcase
    end
  end

  // Step strobe, step counter and value capture.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      step_en_r    <= 1'b0;
      step_count_r <= '0;
      captured     <= '0;
    end else begin
      step_en_r <= div_hit | btn_pulse;
      if (step_en_r) begin
        step_count_r <= step_count_r + 16'd1;
        captured     <= bus.value;
      end
    end
  end

  // Leading-zero blanking: a digit blanks when it and every higher digit are zero; digit 0 never.
  always_comb begin
    logic lead;
    lead  = 1'b1;
    blank = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      if (captured[4*i +: 4] != 4'd0) begin
        lead = 1'b0;
      end
      blank[i] = (BLANK_LZ != 0) && (i != 0) && lead;
    end
  end

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_digit
    hex_seg7 u_seg (
      .nibble (captured[4*g +: 4]),
      .blank  (blank[g]),
      .seg    (hex_nxt[7*g +: 7])
    );
  end

  // Registered display, one cycle behind the captured word.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hex_r <= HEX_RST;
    end else begin
      hex_r <= hex_nxt;
    end
  end

endmodule
